// File: rtl/yarvi_trace_ctrl.sv
// Trace session controller: gates retire records by skip/limit/stop-pc and buffers them in a show-ahead FIFO.
// Latency: a record pushed in cycle N appears on out_* in N+1. out_ready stalls the drain; retire never stalls, drops on full.

module yarvi_trace_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_vld,
    input  logic [W-1:0]             wr_dat,
    output logic                     wr_rdy,
    output logic                     rd_vld,
    output logic [W-1:0]             rd_dat,
    input  logic                     rd_rdy,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          push;
    logic          pop;

    assign rd_vld = (cnt != '0);
    assign pop    = rd_vld & rd_rdy;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign wr_rdy = (cnt != (AW+1)'(DEPTH)) | pop;
    assign push   = wr_vld & wr_rdy;
    assign rd_dat = mem[rd_ptr];
    assign level  = cnt;

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= wr_dat;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      cnt <= cnt + 1'b1;
            else if (pop && !push) cnt <= cnt - 1'b1;
        end
    end
endmodule

module yarvi_trace_ctrl #(
    parameter int DEPTH = 8,
    parameter int PC_W  = 32,
    parameter int D_W   = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [PC_W-1:0] in_pc,
    input  logic [31:0]     in_insn,
    input  logic            in_we,
    input  logic [4:0]      in_addr,
    input  logic [D_W-1:0]  in_d,
    input  logic            cfg_en,
    input  logic [31:0]     cfg_skip,
    input  logic [31:0]     cfg_limit,
    input  logic            cfg_stop_pc_en,
    input  logic [PC_W-1:0] cfg_stop_pc,
    output logic            out_valid,
    output logic [PC_W-1:0] out_pc,
    output logic [31:0]     out_insn,
    output logic            out_we,
    output logic [4:0]      out_addr,
    output logic [D_W-1:0]  out_d,
    input  logic            out_ready,
    output logic [2:0]      state,
    output logic [31:0]     traced_count,
    output logic [15:0]     drop_count
);
    localparam int LW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     insn;
        logic            we;
        logic [4:0]      addr;
        logic [D_W-1:0]  d;
    } rec_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SKIP  = 3'd1,
        TRACE = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        st, st_nxt;
    logic [31:0]   skip_cnt;
    logic          clr, skip_inc, push_try;
    logic          fifo_wr_rdy, fifo_rd_vld, pop, push_ok, push_drop;
    logic [LW-1:0] fifo_level;
    rec_t          in_rec, head_rec, out_rec;

    assign in_rec    = '{pc: in_pc, insn: in_insn, we: in_we, addr: in_addr, d: in_d};
    assign pop       = fifo_rd_vld & out_ready;
    assign push_ok   = push_try & fifo_wr_rdy;
    assign push_drop = push_try & ~fifo_wr_rdy;

    yarvi_trace_fifo #(.DEPTH(DEPTH), .W($bits(rec_t))) u_fifo (
        .clock  (clock),
        .reset  (reset),
        .wr_vld (push_try),
        .wr_dat (in_rec),
        .wr_rdy (fifo_wr_rdy),
        .rd_vld (fifo_rd_vld),
        .rd_dat (head_rec),
        .rd_rdy (out_ready),
        .level  (fifo_level)
    );

    always_comb begin
        st_nxt   = st;
        clr      = 1'b0;
        skip_inc = 1'b0;
        push_try = 1'b0;
        case (st)
            IDLE: if (cfg_en) begin
                clr    = 1'b1;
                st_nxt = (cfg_skip == 32'd0) ? TRACE : SKIP;
            end
            SKIP: if (!cfg_en) begin
                st_nxt = DRAIN;
            end else if (in_valid) begin
                skip_inc = 1'b1;
                if (skip_cnt + 32'd1 == cfg_skip) st_nxt = TRACE;
            end
            TRACE: if (!cfg_en) begin
                st_nxt = DRAIN;
            end else if (in_valid) begin
                push_try = 1'b1;
                // The limit only counts records that actually made it into the FIFO.
                if ((cfg_limit != 32'd0 && push_ok && traced_count + 32'd1 == cfg_limit) ||
                    (cfg_stop_pc_en && in_pc == cfg_stop_pc))
                    st_nxt = DRAIN;
            end
            DRAIN: if (!fifo_rd_vld || (fifo_level == LW'(1) && pop)) st_nxt = DONE;
            DONE:  if (!cfg_en) st_nxt = IDLE;
            default: st_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            st           <= IDLE;
            skip_cnt     <= '0;
            traced_count <= '0;
            drop_count   <= '0;
        end else begin
            st <= st_nxt;
            if (clr) begin
                skip_cnt     <= '0;
                traced_count <= '0;
                drop_count   <= '0;
            end else begin
                if (skip_inc) skip_cnt <= skip_cnt + 32'd1;
                if (push_ok)  traced_count <= traced_count + 32'd1;
                if (push_drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end
        end
    end

    // Stale storage is masked so an empty FIFO presents an all-zero record.
    assign out_rec   = fifo_rd_vld ? head_rec : '0;
    assign out_valid = fifo_rd_vld;
    assign out_pc    = out_rec.pc;
    assign out_insn  = out_rec.insn;
    assign out_we    = out_rec.we;
    assign out_addr  = out_rec.addr;
    assign out_d     = out_rec.d;
    assign state     = st;
endmodule
